// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared elaboration helpers for the carry-save adder tree.
//   CSA_MAX_OPS    : largest supported operand count.
//   csa_vec_count  : number of vectors entering a given compressor level.
//   csa_levels     : number of 3:2 levels needed to reduce n vectors to 2.
// Each 3:2 level turns every full group of three vectors into two and passes
// a leftover one or two vectors straight through.
// -----------------------------------------------------------------------------
package csa_pkg;

    localparam int CSA_MAX_OPS = 16;

    // Vector count after one compressor level.
    function automatic int csa_step(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    // Vectors entering level 'level' (level 0 is the extended operand set).
    function automatic int csa_vec_count(input int n, input int level);
        int cnt;
        cnt = n;
        for (int i = 0; i < CSA_MAX_OPS; i++) begin
            if (i < level && cnt > 2) begin
                cnt = csa_step(cnt);
            end
        end
        return cnt;
    endfunction

    // Levels until only two vectors remain (3->1, 4->2, 6->3, 9->4, 16->6).
    function automatic int csa_levels(input int n);
        int cnt;
        int lv;
        cnt = n;
        lv  = 0;
        for (int i = 0; i < CSA_MAX_OPS; i++) begin
            if (cnt > 2) begin
                cnt = csa_step(cnt);
                lv  = lv + 1;
            end
        end
        return lv;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// -----------------------------------------------------------------------------
// csa_3to2
// Purely combinational 3:2 carry-save compressor row (one full adder per bit).
// Parameters:
//   OUT_W : vector width.
// Ports:
//   a, b, c : input vectors.
//   sum     : bitwise a^b^c.
//   carry   : bitwise majority(a,b,c) shifted left by one, truncated to OUT_W.
// -----------------------------------------------------------------------------
module csa_3to2
    import csa_pkg::*;
#(
    parameter int OUT_W = 7
) (
    input  logic [OUT_W-1:0] a,
    input  logic [OUT_W-1:0] b,
    input  logic [OUT_W-1:0] c,
    output logic [OUT_W-1:0] sum,
    output logic [OUT_W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    // The carry out of bit OUT_W-1 is dropped: the tree works modulo 2^OUT_W.
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_tree_adder.sv
// -----------------------------------------------------------------------------
// csa_tree_adder
// Pipelined multi-operand adder: NUM_OPS operands of WIDTH bits are extended to
// OUT_W bits, reduced to two vectors by a registered tree of 3:2 compressors,
// and summed by a registered carry-propagate adder.
// Latency is csa_levels(NUM_OPS)+2 cycles from accept to out_valid.
//
// Parameters:
//   WIDTH   : operand width (2..32).
//   NUM_OPS : operand count (3..16).
//   OUT_W   : derived result width WIDTH+$clog2(NUM_OPS).
//
// Ports:
//   clk        : clock, rising edge.
//   reset      : asynchronous, active-high; clears every register.
//   flush      : (only with CSA_FLUSH_EN) drops all in-flight transactions.
//   in_valid   : operand set present on in_ops.
//   in_ready   : operand set is accepted this cycle.
//   in_signed  : 1 = operands are two's complement, 0 = unsigned.
//   in_ops     : operand k at bits [k*WIDTH +: WIDTH].
//   out_valid  : out_result holds a completed sum.
//   out_ready  : downstream takes out_result.
//   out_result : sum modulo 2^OUT_W.
//
// Optional feature macro: CSA_FLUSH_EN (adds the flush port).
//
// Flow control is a single global stall: while the output is held, every
// stage holds; otherwise every stage advances. Empty slots are not collapsed.
// -----------------------------------------------------------------------------
module csa_tree_adder
    import csa_pkg::*;
#(
    parameter  int WIDTH   = 4,
    parameter  int NUM_OPS = 6,
    localparam int OUT_W   = WIDTH + $clog2(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef CSA_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_signed,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_result
);

    localparam int LEVELS = csa_levels(NUM_OPS);

    logic stall;
    logic advance;
    logic flush_req;

    assign stall   = out_valid && !out_ready;
    assign advance = !stall;

`ifdef CSA_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // A flush cycle refuses input so the dropped set is never reported as taken.
    assign in_ready = advance && !flush_req;

    // Extend one operand to OUT_W bits, sign- or zero-filled.
    function automatic logic [OUT_W-1:0] extend_op(input logic [WIDTH-1:0] op,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] s_op;
        logic signed [OUT_W-1:0] s_ext;
        s_op  = op;
        s_ext = s_op;
        return is_signed ? s_ext : {{(OUT_W-WIDTH){1'b0}}, op};
    endfunction

    // lvl[0] holds the extended operands; lvl[l] holds the output of
    // compressor level l. lvl[LEVELS] always carries exactly two vectors.
    for (genvar l = 0; l <= LEVELS; l++) begin : lvl
        localparam int N = csa_vec_count(NUM_OPS, l);

        logic [OUT_W-1:0] vec_p [N];
        logic             vld_p;

        if (l == 0) begin : g_in
            // ---- stage p0: operand extension register ----
            logic [OUT_W-1:0] ext [N];

            for (genvar k = 0; k < N; k++) begin : g_ext
                assign ext[k] = extend_op(in_ops[k*WIDTH +: WIDTH], in_signed);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < N; k++) begin
                        vec_p[k] <= '0;
                    end
                end else if (advance) begin
                    for (int k = 0; k < N; k++) begin
                        vec_p[k] <= ext[k];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p <= 1'b0;
                end else if (flush_req) begin
                    vld_p <= 1'b0;
                end else if (advance) begin
                    vld_p <= in_valid;
                end
            end
        end else begin : g_csa
            // ---- stage p<l>: 3:2 compressor level register ----
            localparam int NP = csa_vec_count(NUM_OPS, l - 1);
            localparam int G  = NP / 3;
            localparam int R  = NP % 3;

            logic [OUT_W-1:0] nxt [N];

            for (genvar g = 0; g < G; g++) begin : g_grp
                csa_3to2 #(
                    .OUT_W (OUT_W)
                ) u_csa (
                    .a     (lvl[l-1].vec_p[3*g]),
                    .b     (lvl[l-1].vec_p[3*g+1]),
                    .c     (lvl[l-1].vec_p[3*g+2]),
                    .sum   (nxt[2*g]),
                    .carry (nxt[2*g+1])
                );
            end

            // Vectors that do not fill a group skip this level's compressors.
            for (genvar r = 0; r < R; r++) begin : g_pass
                assign nxt[2*G+r] = lvl[l-1].vec_p[3*G+r];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < N; k++) begin
                        vec_p[k] <= '0;
                    end
                end else if (advance) begin
                    for (int k = 0; k < N; k++) begin
                        vec_p[k] <= nxt[k];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p <= 1'b0;
                end else if (flush_req) begin
                    vld_p <= 1'b0;
                end else if (advance) begin
                    vld_p <= lvl[l-1].vld_p;
                end
            end
        end
    end

    // ---- output stage: carry-propagate adder register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (flush_req) begin
                out_valid <= 1'b0;
            end else if (advance) begin
                out_valid <= lvl[LEVELS].vld_p;
            end
            if (advance) begin
                out_result <= lvl[LEVELS].vec_p[0] + lvl[LEVELS].vec_p[1];
            end
        end
    end

endmodule
